// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text path: HD44780 command bytes, sequencer
// state encoding and init-list length. Also used by the byte-transfer controller.
// No logic; constants and types only.
package lcd_pkg;

    // HD44780 command bytes
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, home cursor
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address 0x40

    localparam logic [7:0] LCD_BLANK    = 8'h20;  // ASCII space

    localparam int LCD_INIT_LEN = 6;

    // ISSUE states last one cycle (lcd_start high); WAIT states wait for lcd_done.
    typedef enum logic [2:0] {
        ST_PWR_WAIT   = 3'd0,
        ST_INIT_ISSUE = 3'd1,
        ST_INIT_WAIT  = 3'd2,
        ST_IDLE       = 3'd3,
        ST_ROW_ADDR   = 3'd4,
        ST_ROW_WAIT   = 3'd5,
        ST_CHARS      = 3'd6,
        ST_CHAR_WAIT  = 3'd7
    } lcd_state_t;

endpackage

// File: rtl/lcd_char_buffer.sv
// 32x8 character buffer: index 0-15 = line 1, 16-31 = line 2; resets to spaces.
// Write takes effect at the next clk edge; read is combinational (zero latency).
// No backpressure: a write is accepted every cycle.
// Ports: clk, reset (sync, high); wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module lcd_char_buffer
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= LCD_BLANK;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// HD44780 init + 2x16 redraw sequencer driving a byte-transfer controller via start/done.
// Latency: lcd_start one cycle after the triggering update/done; all outputs registered.
// Backpressure: one byte outstanding; waits for lcd_done; updates while busy fold into a pending flag.
// Ports: clk, reset (sync, high); wr_en/wr_addr/wr_data char writes; update redraw pulse;
//        busy, init_done status; lcd_data/lcd_rs/lcd_start to controller, lcd_done back.
// Build option: define LCD_AUTO_REFRESH_EN for a periodic internal redraw every REFRESH_CYCLES.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750_000,
    parameter int unsigned REFRESH_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       update,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_start,
    input  logic       lcd_done
);

    // Elaboration-time sanity on the configuration.
    if (POWERUP_CYCLES < 1) begin : g_bad_powerup
        $error("POWERUP_CYCLES must be at least 1");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be at least 2");
    end

    localparam int unsigned PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

    lcd_state_t       state, state_nxt;
    logic [PWR_W-1:0] pwr_cnt;
    logic             pwr_last;
    logic [2:0]       init_idx, init_idx_nxt;
    logic [4:0]       char_idx, char_idx_nxt;
    logic             pending;
    logic             upd;
    logic             issue;
    logic             issue_rs;
    logic [7:0]       issue_data;
    logic [7:0]       init_cmd;
    logic [7:0]       rd_data;

    // ------------------------------------------------------------------
    // Redraw trigger: port pulse, optionally ORed with the refresh timer.
    // ------------------------------------------------------------------
`ifdef LCD_AUTO_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);

    logic [REF_W-1:0] refresh_cnt;
    logic             refresh_pulse;

    // Free-running once init has completed; one-cycle pulse per period.
    always_ff @(posedge clk) begin
        if (reset || !init_done) begin
            refresh_cnt   <= '0;
            refresh_pulse <= 1'b0;
        end else if (refresh_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt   <= '0;
            refresh_pulse <= 1'b1;
        end else begin
            refresh_cnt   <= refresh_cnt + 1'b1;
            refresh_pulse <= 1'b0;
        end
    end

    assign upd = update | refresh_pulse;
`else
    assign upd = update;
`endif

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    // Read address follows the index about to be issued, so the byte is
    // sampled in the same cycle the start request is registered.
    lcd_char_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (char_idx_nxt),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Power-up delay counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pwr_cnt <= '0;
        end else if (state == ST_PWR_WAIT && !pwr_last) begin
            pwr_cnt <= pwr_cnt + 1'b1;
        end
    end

    assign pwr_last = (pwr_cnt == PWR_W'(POWERUP_CYCLES - 1));

    // ------------------------------------------------------------------
    // Init command ROM, indexed by the entry about to be issued
    // ------------------------------------------------------------------
    always_comb begin
        init_cmd = LCD_FUNC_SET;
        case (init_idx_nxt)
            3'd0, 3'd1, 3'd2: init_cmd = LCD_FUNC_SET;
            3'd3:             init_cmd = LCD_DISP_ON;
            3'd4:             init_cmd = LCD_CLEAR;
            3'd5:             init_cmd = LCD_ENTRY;
            default:          init_cmd = LCD_FUNC_SET;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_PWR_WAIT;
            init_idx <= '0;
            char_idx <= '0;
        end else begin
            state    <= state_nxt;
            init_idx <= init_idx_nxt;
            char_idx <= char_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. 'issue' means the next cycle is an ISSUE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        init_idx_nxt = init_idx;
        char_idx_nxt = char_idx;
        issue        = 1'b0;
        issue_rs     = 1'b0;

        case (state)
            ST_PWR_WAIT: begin
                if (pwr_last) begin
                    state_nxt    = ST_INIT_ISSUE;
                    init_idx_nxt = '0;
                    issue        = 1'b1;
                end
            end
            ST_INIT_ISSUE: state_nxt = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (lcd_done) begin
                    if (init_idx == 3'(LCD_INIT_LEN - 1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt    = ST_INIT_ISSUE;
                        init_idx_nxt = init_idx + 1'b1;
                        issue        = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (upd || pending) begin
                    state_nxt    = ST_ROW_ADDR;
                    char_idx_nxt = '0;
                    issue        = 1'b1;
                end
            end
            ST_ROW_ADDR: state_nxt = ST_ROW_WAIT;
            ST_ROW_WAIT: begin
                if (lcd_done) begin
                    state_nxt = ST_CHARS;
                    issue     = 1'b1;
                    issue_rs  = 1'b1;
                end
            end
            ST_CHARS: state_nxt = ST_CHAR_WAIT;
            ST_CHAR_WAIT: begin
                if (lcd_done) begin
                    if (char_idx == 5'd31) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        char_idx_nxt = char_idx + 1'b1;
                        issue        = 1'b1;
                        // End of line 1: reposition the cursor before index 16.
                        if (char_idx == 5'd15) begin
                            state_nxt = ST_ROW_ADDR;
                        end else begin
                            state_nxt = ST_CHARS;
                            issue_rs  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_PWR_WAIT;
        endcase
    end

    always_comb begin
        issue_data = init_cmd;
        if (issue_rs) begin
            issue_data = rd_data;
        end else if (state_nxt == ST_ROW_ADDR) begin
            issue_data = char_idx_nxt[4] ? LCD_LINE2 : LCD_LINE1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and pending flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_start <= 1'b0;
            lcd_data  <= 8'h00;
            lcd_rs    <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            pending   <= 1'b0;
        end else begin
            lcd_start <= issue;
            // data/rs only change when a new byte is issued, so they hold
            // from the start cycle through done.
            if (issue) begin
                lcd_data <= issue_data;
                lcd_rs   <= issue_rs;
            end
            busy <= (state_nxt != ST_IDLE);
            if (state == ST_INIT_WAIT && state_nxt == ST_IDLE) begin
                init_done <= 1'b1;
            end
            // IDLE consumes the flag (and any same-cycle update); anywhere
            // else an update is remembered, saturating at one.
            if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (upd) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Self-checking bench for lcd_text_sequencer with a 5-cycle behavioural done responder.
// Expected transfers come from a transfer-position model over a mirror of the char buffer.
// Stimulus mixes fixed scenarios with $urandom writes and update spacing.
module tb_lcd_text_sequencer;

    localparam int PWR = 10;
    localparam int REF = 2000;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       update = 1'b0;
    logic       lcd_done;
    logic       busy;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_start;

    always #5 clk = ~clk;

    lcd_text_sequencer #(
        .POWERUP_CYCLES (PWR),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .update    (update),
        .busy      (busy),
        .init_done (init_done),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_start (lcd_start),
        .lcd_done  (lcd_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] model_buf [32];
    logic [7:0] init_list [6];

    initial begin
        init_list[0] = 8'h38; init_list[1] = 8'h38; init_list[2] = 8'h38;
        init_list[3] = 8'h0C; init_list[4] = 8'h01; init_list[5] = 8'h06;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    end

    // Transfer number p since reset -> {rs, byte}
    function automatic logic [8:0] expected_xfer(input int p);
        int r;
        if (p < 6) return {1'b0, init_list[p]};
        r = (p - 6) % 34;
        if (r == 0)  return {1'b0, 8'h80};
        if (r == 17) return {1'b0, 8'hC0};
        if (r < 17)  return {1'b1, model_buf[r - 1]};
        return {1'b1, model_buf[r - 2]};
    endfunction

    // ---------------- done responder + monitor ----------------
    int         pos = 0;
    int         cyc = 0;
    int         row1_last = 0;
    int         row1_prev = 0;
    logic       outstanding = 1'b0;
    logic       prev_start = 1'b0;
    int         lat_cnt = 0;
    logic [8:0] cap = '0;

    initial lcd_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pos         = 0;
            outstanding = 1'b0;
            lat_cnt     = 0;
            lcd_done    = 1'b0;
            prev_start  = 1'b0;
        end else begin
            if (lcd_done) lcd_done = 1'b0;
            if (lcd_start) begin
                check("start_gap", {31'd0, prev_start}, 32'd0);
                check("start_before_done", {31'd0, outstanding}, 32'd0);
                check($sformatf("xfer%0d", pos), {23'd0, lcd_rs, lcd_data}, {23'd0, expected_xfer(pos)});
                if ({lcd_rs, lcd_data} == 9'h080) begin
                    row1_prev = row1_last;
                    row1_last = cyc;
                end
                cap         = {lcd_rs, lcd_data};
                pos++;
                outstanding = 1'b1;
                lat_cnt     = LAT;
            end else if (outstanding) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    check("hold", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
                    lcd_done    = 1'b1;
                    outstanding = 1'b0;
                end
            end
            prev_start = lcd_start;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[4:0];
        wr_data = d;
        model_buf[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        for (int i = 0; i < budget && quiet < 4; i++) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
        end
        check(tag, (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_pos(input string tag, input int target, input int budget);
        int i = 0;
        while (pos < target && i < budget) begin
            tick();
            i++;
        end
        check(tag, (pos >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_init(input string tag);
        int i = 0;
        while (!init_done && i < 500) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        check({tag, "_busy_after_init"}, {31'd0, busy}, 32'd0);
        check({tag, "_init_count"}, pos, 32'd6);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base;

        // 1: reset state, power-up delay, init list
        repeat (3) tick();
        @(negedge clk);
        check("rst_start", {31'd0, lcd_start}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < PWR; i++) begin
            @(negedge clk);
            check($sformatf("pwr_wait%0d", i), {31'd0, lcd_start}, 32'd0);
        end
        @(negedge clk);
        check("first_start", {31'd0, lcd_start}, 32'd1);
        check("first_cmd", {23'd0, lcd_rs, lcd_data}, 32'h038);
        wait_init("t1");

        // 2: HELLO redraw
        write_char(0, 8'h48); write_char(1, 8'h45); write_char(2, 8'h4C);
        write_char(3, 8'h4C); write_char(4, 8'h4F);
        base = pos;
        pulse_update();
        wait_idle("t2_idle", 2000);
`ifndef LCD_AUTO_REFRESH_EN
        check("t2_count", pos - base, 32'd34);
`endif

        // random buffer contents
        for (int k = 0; k < 10; k++) begin
            write_char(int'($urandom_range(0, 31)), 8'($urandom_range(8'h21, 8'h7E)));
        end
        base = pos;
        pulse_update();
        wait_idle("trnd_idle", 2000);
`ifndef LCD_AUTO_REFRESH_EN
        check("trnd_count", pos - base, 32'd34);
`endif

        // 3: three updates during a redraw -> one extra redraw
        base = pos;
        pulse_update();
        wait_pos("t3_started", base + 3, 500);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 20)) tick();
            pulse_update();
        end
        wait_idle("t3_idle", 4000);
`ifndef LCD_AUTO_REFRESH_EN
        check("t3_count", pos - base, 32'd68);
`endif
        check("t3_busy", {31'd0, busy}, 32'd0);

        // 4: mid-redraw writes after char 5 has been issued
        base = pos;
        pulse_update();
        wait_pos("t4_char5", base + 7, 500);
        write_char(3, 8'h41);
        write_char(20, 8'h42);
        wait_idle("t4_idle_a", 2000);
        pulse_update();
        wait_idle("t4_idle_b", 2000);
`ifndef LCD_AUTO_REFRESH_EN
        check("t4_count", pos - base, 32'd68);
`endif

        // 5: reset during a character WAIT_DONE; update during power-up wait
        base = pos;
        pulse_update();
        wait_pos("t5_char", base + 4, 500);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_start", {31'd0, lcd_start}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd1);
        check("t5_init_done", {31'd0, init_done}, 32'd0);
        tick();
        pulse_update();
        wait_init("t5");
        wait_idle("t5_idle", 2000);
`ifndef LCD_AUTO_REFRESH_EN
        check("t5_count", pos, 32'd40);
`endif

        // 6: auto refresh behaviour
`ifdef LCD_AUTO_REFRESH_EN
        repeat (4500) tick();
        check("t6_period", row1_last - row1_prev, REF);
`else
        base = pos;
        repeat (3000) tick();
        check("t6_no_refresh", pos - base, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
